// File: rtl/uart_tx_fifo_rd.sv
// UART transmitter on the read side of a TX FIFO: pops one byte per frame and serialises it LSB first.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_rd #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // Tick counter must reach SB_TICK-1 in STOP as well as 15 in the other states
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]      state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            tx_next;
  logic            rd_raw, done_raw;
`ifdef UART_TX_PARITY_EN
  logic            par, par_next;
`endif

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    rd_raw     = 1'b0;
    done_raw   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_raw     = 1'b1;
          b_next     = fifo_rdata;
          s_next     = '0;
`ifdef UART_TX_PARITY_EN
          par_next   = ^fifo_rdata;
`endif
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == 3'(DBIT-1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK-1)) begin
            done_raw   = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is decoded from the next state so the line is a pure register output
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      tx    <= tx_next;
    end
  end

  always_ff @(posedge clk) begin
    b <= b_next;
`ifdef UART_TX_PARITY_EN
    par <= par_next;
`endif
  end

  assign fifo_rd      = rd_raw & ~reset;
  assign tx_done_tick = done_raw & ~reset;
  assign tx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Directed bench for uart_tx_fifo_rd: a FIFO model, a tick generator and a tick-resolution line log.
// A second instance with SB_TICK=32 covers the two-stop-bit frame.
module tb_uart_tx_fifo_rd;
  localparam int DBIT = 8;
  localparam int TDIV = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBIT + 2;
`else
  localparam int NB = DBIT + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       sel32 = 1'b0;
  logic [7:0] fifo_rdata = 8'h00;
  logic       rd_a, tx_a, busy_a, done_a;
  logic       rd_b, tx_b, busy_b, done_b;
  logic       txm, rdm, donem;

  uart_tx_fifo_rd #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty | sel32),
    .fifo_rdata(fifo_rdata), .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a));

  uart_tx_fifo_rd #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty | ~sel32),
    .fifo_rdata(fifo_rdata), .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b));

  assign txm   = sel32 ? tx_b   : tx_a;
  assign rdm   = sel32 ? rd_b   : rd_a;
  assign donem = sel32 ? done_b : done_a;

  logic [7:0] q[$];
  bit         tick_log[$];
  int         done_q[$];
  int         rd_cnt = 0, lat_err = 0, tdiv = 0;
  bit         pop_pend = 0, tick_en = 0, force_empty = 0;
  int         checks = 0, errors = 0;

  // FIFO model, tick generator and line monitor; inputs change on negedge, outputs read 1 ns later
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pend && txm !== 1'b0) lat_err++;
      pop_pend   = 0;
      fifo_empty = force_empty || (q.size() == 0);
      fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
      if (tick_en) begin
        if (tdiv == TDIV-1) begin
          tdiv = 0;
          s_tick = 1'b1;
          tick_log.push_back(txm);
        end else begin
          tdiv++;
          s_tick = 1'b0;
        end
      end else begin
        tdiv = 0;
        s_tick = 1'b0;
      end
      #1;
      if (rdm === 1'b1) begin
        rd_cnt++;
        if (q.size() != 0) void'(q.pop_front());
        pop_pend = 1;
      end
      if (donem === 1'b1) done_q.push_back(tick_log.size());
    end
  end

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() >= target) begin
        ok = 1;
        break;
      end
      @(negedge clk); #2;
    end
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (txm === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Recover one frame from the tick log: first low tick is the start bit, bits sampled mid-period
  task automatic decode(input int from, output int i0, output logic [7:0] data,
                        output logic par, output int bad);
    logic bitv;
    i0 = -1; data = 8'h00; par = 1'b0; bad = 0;
    for (int i = from; i < tick_log.size(); i++)
      if (tick_log[i] == 1'b0) begin
        i0 = i;
        break;
      end
    if (i0 < 0 || i0 + 16*NB > tick_log.size()) begin
      bad = 1;
      return;
    end
    for (int j = 0; j < 16; j++) if (tick_log[i0+j] != 1'b0) bad++;
    for (int k = 0; k < NB-1; k++) begin
      bitv = tick_log[i0 + 16*(k+1) + 8];
      for (int j = 0; j < 16; j++) if (tick_log[i0 + 16*(k+1) + j] != bitv) bad++;
      if (k < DBIT) data[k] = bitv;
      else par = bitv;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx32: got %b want 1", tx_b); end
    @(posedge clk); #2;
    q.push_back(8'h5A);
    repeat (4) @(posedge clk);
    #2;
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_rd_held: got %b want 0", rd_a); end
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL reset_no_pop: got %0d pops want 0", rd_cnt); end
    q.delete();
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    tick_en = 1;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_single;
    int base_rd, base_done, from, lat0, i0, bad, len;
    logic [7:0] data;
    logic par;
    bit ok;
    base_rd = rd_cnt; base_done = done_q.size(); from = tick_log.size(); lat0 = lat_err;
    @(posedge clk); #2;
    q.push_back(8'hA5);
    wait_done(base_done + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no tx_done_tick want 1"); end
    repeat (40) @(posedge clk);
    #2;
    decode(from, i0, data, par, bad);
    len = (done_q.size() > base_done) ? done_q[base_done] - i0 : -1;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_shape: got %0d bad ticks want 0", bad); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", data); end
    checks++; if (rd_cnt - base_rd != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", rd_cnt - base_rd); end
    checks++; if (done_q.size() - base_done != 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_q.size() - base_done); end
    checks++; if (len != 16*NB + 16) begin errors++; $display("FAIL single_len: got %0d ticks want %0d", len, 16*NB + 16); end
    checks++; if (lat_err != lat0) begin errors++; $display("FAIL single_latency: got %0d late start bits want 0", lat_err - lat0); end
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL single_idle: got tx=%b busy=%b want 1 0", tx_a, busy_a); end
  endtask

  task automatic test_back_to_back;
    int base_rd, base_done, from, i0a, i0b, bad, gap;
    logic [7:0] data;
    logic par;
    bit ok;
    base_rd = rd_cnt; base_done = done_q.size(); from = tick_log.size();
    @(posedge clk); #2;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    wait_done(base_done + 2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d frames want 2", done_q.size() - base_done); end
    repeat (40) @(posedge clk);
    #2;
    if (ok) begin
      decode(from, i0a, data, par, bad);
      checks++; if (bad != 0 || data !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h bad=%0d want 00", data, bad); end
      decode(done_q[base_done], i0b, data, par, bad);
      checks++; if (bad != 0 || data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h bad=%0d want ff", data, bad); end
      gap = i0b - done_q[base_done];
      checks++; if (gap < 0 || gap > 16) begin errors++; $display("FAIL b2b_gap: got %0d ticks want 0..16", gap); end
    end
    checks++; if (rd_cnt - base_rd != 2) begin errors++; $display("FAIL b2b_pops: got %0d want 2", rd_cnt - base_rd); end
    checks++; if (done_q.size() - base_done != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_q.size() - base_done); end
  endtask

  task automatic test_stop32;
    int base_rd, base_done, from, i0, bad, len;
    logic [7:0] data;
    logic par;
    bit ok;
    @(posedge clk); #2;
    sel32 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    base_rd = rd_cnt; base_done = done_q.size(); from = tick_log.size();
    q.push_back(8'h3C);
    wait_done(base_done + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop32_timeout: got no tx_done_tick want 1"); end
    decode(from, i0, data, par, bad);
    len = (done_q.size() > base_done) ? done_q[base_done] - i0 : -1;
    checks++; if (bad != 0 || data !== 8'h3C) begin errors++; $display("FAIL stop32_data: got %h bad=%0d want 3c", data, bad); end
    checks++; if (len != 16*NB + 32) begin errors++; $display("FAIL stop32_len: got %0d ticks want %0d", len, 16*NB + 32); end
    checks++; if (rd_cnt - base_rd != 1) begin errors++; $display("FAIL stop32_pops: got %0d want 1", rd_cnt - base_rd); end
    repeat (4) @(posedge clk);
    #2;
    sel32 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int base_done, from, i0, bad, len;
    logic [7:0] data;
    logic par;
    bit ok;
    base_done = done_q.size(); from = tick_log.size();
    @(posedge clk); #2;
    q.push_back(8'h07);
    q.push_back(8'h03);
    wait_done(base_done + 2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL parity_timeout: got %0d frames want 2", done_q.size() - base_done); end
    if (ok) begin
      decode(from, i0, data, par, bad);
      len = done_q[base_done] - i0;
      checks++; if (bad != 0 || data !== 8'h07 || par !== 1'b1) begin errors++; $display("FAIL parity_first: got %h par=%b want 07 par=1", data, par); end
      checks++; if (len != 16*11) begin errors++; $display("FAIL parity_len: got %0d ticks want 176", len); end
      decode(done_q[base_done], i0, data, par, bad);
      checks++; if (bad != 0 || data !== 8'h03 || par !== 1'b0) begin errors++; $display("FAIL parity_second: got %h par=%b want 03 par=0", data, par); end
    end
  endtask
`endif

  task automatic test_stall;
    int base_rd, base_done, from, logn, i0, bad;
    logic [7:0] data;
    logic par;
    bit ok;
    base_rd = rd_cnt; base_done = done_q.size(); from = tick_log.size();
    @(posedge clk); #2;
    q.push_back(8'h5A);
    wait_tx_low(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_start: got no start bit want tx=0"); end
    @(posedge clk); #2;
    tick_en = 0;
    q.push_back(8'h33);
    logn = tick_log.size();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (i % 37 == 0) force_empty = ~force_empty;
    end
    checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL stall_tx: got %b want 0", tx_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy_a); end
    checks++; if (rd_cnt - base_rd != 1) begin errors++; $display("FAIL stall_pops: got %0d want 1", rd_cnt - base_rd); end
    force_empty = 0;
    tick_en = 1;
    wait_done(base_done + 2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d frames want 2", done_q.size() - base_done); end
    if (ok) begin
      decode(from, i0, data, par, bad);
      checks++; if (bad != 0 || data !== 8'h5A) begin errors++; $display("FAIL stall_first: got %h bad=%0d want 5a", data, bad); end
      decode(done_q[base_done], i0, data, par, bad);
      checks++; if (bad != 0 || data !== 8'h33) begin errors++; $display("FAIL stall_second: got %h bad=%0d want 33", data, bad); end
    end
    checks++; if (rd_cnt - base_rd != 2) begin errors++; $display("FAIL stall_total_pops: got %0d want 2", rd_cnt - base_rd); end
    if (logn == 0) logn = 0;
  endtask

  task automatic test_reset_mid_frame;
    int base_rd, base_done, from, i0, bad;
    logic [7:0] data;
    logic par;
    bit ok;
    base_rd = rd_cnt; base_done = done_q.size();
    @(posedge clk); #2;
    q.push_back(8'h11);
    q.push_back(8'h22);
    wait_tx_low(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_start: got no start bit want tx=0"); end
    repeat (60) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk); #2;
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL rst_cycle_rd: got %b want 0", rd_a); end
    @(posedge clk); #2;
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) begin errors++; $display("FAIL rst_next: got tx=%b busy=%b rd=%b want 1 0 0", tx_a, busy_a, rd_a); end
    @(posedge clk); #2;
    checks++; if (rd_cnt - base_rd != 1) begin errors++; $display("FAIL rst_hold_pops: got %0d want 1", rd_cnt - base_rd); end
    from = tick_log.size();
    reset = 1'b0;
    wait_done(base_done + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_timeout: got no tx_done_tick want 1"); end
    repeat (40) @(posedge clk);
    #2;
    decode(from, i0, data, par, bad);
    checks++; if (bad != 0 || data !== 8'h22) begin errors++; $display("FAIL rst_resume_data: got %h bad=%0d want 22", data, bad); end
    checks++; if (rd_cnt - base_rd != 2) begin errors++; $display("FAIL rst_total_pops: got %0d want 2", rd_cnt - base_rd); end
    checks++; if (done_q.size() - base_done != 1) begin errors++; $display("FAIL rst_done: got %0d want 1", done_q.size() - base_done); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stop32;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    test_stall;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
